instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction-fetch stage of the RISC-V core, sitting directly upstream of the main decoder: it holds the program counter, issues word fetches to instruction memory over a request/response handshake, and presents one instruction at a time (`Instr`, whose bits [6:0] drive the decoder's `Op`) with its PC. It applies branch redirects (`PCSrc`/`PCTarget`) from the datapath when the presented instruction is consumed. It counts retired instructions and traps misaligned branch targets.

## Interface
- `RESET_PC`, 32'h0000_0000, PC of the first fetch after reset
- `NOP_INSTR`, 32'h0000_0013, value driven on `Instr` while no instruction is valid (addi x0,x0,0)

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `PCSrc`  in  1  branch taken for the currently presented instruction
- `PCTarget`  in  32  branch target; sampled only on consume with `PCSrc`=1
- `Stall`  in  1  downstream cannot accept the presented instruction
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch byte address, word aligned
- `imem_ready`  in  1  memory accepts the request this cycle
- `imem_rvalid`  in  1  response valid
- `imem_rdata`  in  32  response instruction word
- `Instr`  out  32  presented instruction
- `PC`  out  32  address of `Instr`
- `PCPlus4`  out  32  `PC` + 4, modulo 2^32
- `InstrValid`  out  1  `Instr`/`PC` hold a fetched instruction
- `Fault`  out  1  sticky misaligned-redirect flag
- `InstrCount`  out  32  number of consumed instructions, wraps

## Operation
- States: FETCH, WAIT, VALID, HALT. Single outstanding request.
- FETCH: `imem_req`=1, `imem_addr`=fetch PC. Request accepted on a cycle where `imem_req` & `imem_ready` -> WAIT. `imem_addr` must not change while `imem_req` is high and not accepted.
- WAIT: `imem_req`=0. On `imem_rvalid`: capture `imem_rdata` into `Instr` and fetch PC into `PC` -> VALID.
- VALID: `InstrValid`=1; `Instr`, `PC` and `PCPlus4` are stable. Consume = `InstrValid` & !`Stall` at the edge. On consume, `InstrCount`++ and the next fetch PC is `PCSrc` ? `PCTarget` : `PCPlus4`. The block then goes to FETCH, or to HALT if a redirect target has bits [1:0] != 0.
- HALT: `Fault`=1, `imem_req`=0, `InstrValid`=0. The block stays in HALT until `rst`. On entry to HALT, `PC` holds the faulting target.
- `imem_rvalid` outside WAIT is ignored. This covers a stale response after a reset mid-WAIT.
- `PCSrc`/`PCTarget` are ignored unless a consume happens. `Stall` is ignored outside VALID.
- PC arithmetic is 32-bit and unsigned; 0xFFFF_FFFC + 4 = 0x0000_0000.
- Reset values: state FETCH, fetch PC = `RESET_PC`, `PC` = `RESET_PC`, `Instr` = `NOP_INSTR`, `InstrValid`=0, `Fault`=0, `InstrCount`=0. `imem_req`=0 while `rst` is high.

## Timing
- First request is in the cycle after `rst` deasserts (`imem_req`=1, `imem_addr`=`RESET_PC`).
- `imem_rvalid` arrives at least 1 cycle after acceptance. `InstrValid` rises the cycle after `imem_rvalid`.
- `InstrValid` falls the cycle after a consume, and the next `imem_req` is asserted in that same cycle.
- With `imem_ready`=1 and 1-cycle response, steady-state throughput is 1 instruction per 3 cycles.
- `imem_req`, `imem_addr`, `InstrValid`, `Fault` and `PCPlus4` decode from registered state only; there are no combinational paths from inputs.
- `rst` in any state (including WAIT or HALT) returns the block to reset values at that edge.

## Test plan
- Reset, `RESET_PC`=0: after `rst` falls, `imem_req`=1 and `imem_addr`=0x0. Drive `imem_ready`=1, then `imem_rvalid`=1 with 0x00500093 one cycle later. Required: next cycle `InstrValid`=1, `Instr`=0x00500093, `PC`=0x0, `PCPlus4`=0x4.
- Stall: hold `Stall`=1 for 3 cycles in VALID. Required: `Instr`/`PC` stable and `imem_req`=0. Release `Stall`. Required: next cycle `imem_addr`=0x4 and `InstrCount`=1.
- Branch: consume with `PCSrc`=1, `PCTarget`=0x40. Required: `imem_addr`=0x40. A spurious `imem_rvalid` during FETCH is ignored (`InstrValid` stays 0).
- Backpressure: `imem_ready`=0 for 4 cycles, then `imem_rvalid` 3 cycles after acceptance. Required: `imem_req`/`imem_addr` stable throughout and exactly one instruction delivered.
- Fault: consume with `PCSrc`=1, `PCTarget`=0x42. Required: `Fault`=1, `PC`=0x42, `imem_req`=0 and `InstrValid`=0 for 10+ cycles. `rst` clears everything.
- Wrap and reset mid-operation: with `RESET_PC`=0xFFFF_FFFC, consume with `PCSrc`=0. Required: `imem_addr`=0x0. Assert `rst` during WAIT. Required: next cycle state FETCH with `imem_req`=0 while `rst` is high, and `InstrCount`=0.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: holds the PC, issues one word fetch at a time,
// presents the fetched instruction to the decoder, applies branch redirects
// on consume, counts retired instructions and halts on misaligned targets.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       PCSrc,
  input  logic [31:0]                PCTarget,
  input  logic                       Stall,
  instr_fetch_unit_if.master         imem,
  output logic [31:0]                Instr,
  output logic [31:0]                PC,
  output logic [31:0]                PCPlus4,
  output logic                       InstrValid,
  output logic                       Fault,
  output logic [31:0]                InstrCount
);

  typedef enum logic [1:0] {FETCH, WAIT, VALID, HALT} state_t;

  state_t      r_state;
  state_t      w_state_next;
  // Set at every reset edge and cleared on the first edge with rst low, so
  // imem_req stays low while rst is held without a path from the rst pin.
  logic        r_in_reset;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_count;

  logic        w_req;
  logic        w_accept;
  logic        w_capture;
  logic        w_consume;
  logic        w_misaligned;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_fetch_pc;

  assign w_req           = (r_state == FETCH) && !r_in_reset;
  assign w_accept        = w_req && imem.imem_ready;
  // Responses are only meaningful while a request is outstanding; anything
  // else (including a stale response after reset) is dropped.
  assign w_capture       = (r_state == WAIT) && imem.imem_rvalid;
  assign w_consume       = (r_state == VALID) && !Stall;
  assign w_pc_plus4      = r_pc + 32'd4;
  assign w_misaligned    = PCSrc && (PCTarget[1:0] != 2'b00);
  assign w_next_fetch_pc = PCSrc ? PCTarget : w_pc_plus4;

  // State register and reset-hold flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FETCH;
      r_in_reset <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_in_reset <= 1'b0;
    end
  end

  // Next-state decode for the single-outstanding-request fetch sequence.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FETCH: if (w_accept)  w_state_next = WAIT;
      WAIT:  if (w_capture) w_state_next = VALID;
      VALID: if (w_consume) w_state_next = w_misaligned ? HALT : FETCH;
      HALT:  w_state_next = HALT;
      default: w_state_next = FETCH;
    endcase
  end

  // Datapath: capture responses, advance the fetch PC and retire count on consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_pc       <= RESET_PC;
      r_instr    <= NOP_INSTR;
      r_count    <= 32'd0;
    end else begin
      if (w_capture) begin
        r_instr <= imem.imem_rdata;
        r_pc    <= r_fetch_pc;
      end
      if (w_consume) begin
        r_count    <= r_count + 32'd1;
        r_fetch_pc <= w_next_fetch_pc;
        // The faulting target stays visible on PC while halted.
        if (w_misaligned) r_pc <= PCTarget;
      end
    end
  end

  assign imem.imem_req  = w_req;
  // Only changes on consume, so it is stable while a request waits for ready.
  assign imem.imem_addr = r_fetch_pc;

  assign InstrValid = (r_state == VALID);
  assign Fault      = (r_state == HALT);
  assign Instr      = (r_state == VALID) ? r_instr : NOP_INSTR;
  assign PC         = r_pc;
  assign PCPlus4    = w_pc_plus4;
  assign InstrCount = r_count;

endmodule
